// File: rtl/arb_pkg.sv
// arb_pkg: shared constants and state encoding for the 4-way priority arbiter.
package arb_pkg;
    localparam int N_REQ = 4;
    localparam logic [2:0] NO_OWNER = 3'd7;
    typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/prio_pick.sv
// prio_pick: highest set bit number of a 4-bit vector, or NO_OWNER when empty.
module prio_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] vec_i,
    output logic [2:0]       id_o
);
    always_comb id_o = vec_i[3] ? 3'd3 : vec_i[2] ? 3'd2 : vec_i[1] ? 3'd1 : vec_i[0] ? 3'd0 : NO_OWNER;
endmodule

// File: rtl/priority_arbiter_ctrl.sv
// priority_arbiter_ctrl: 4-way fixed/round-robin arbiter with a hold limit and
// a one-arbitration penalty on the requester that was force-revoked.
module priority_arbiter_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 15
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [N_REQ-1:0] req,
    input  logic             rr_mode,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       grant_id,
    output logic             busy,
    output logic             timeout
);
    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);
    state_t           state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [2:0]       id_q, id_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] pen_q, pen_d;
    logic [1:0]       last_q, last_d;
    logic             tmo_q, tmo_d;
    logic [N_REQ-1:0] elig, rot, pick_vec;
    logic [2:0]       pick_id;
    logic [1:0]       win;
    logic             held;
    assign elig = req & ~pen_q;
    // Rotate so that requester last_owner-1 sits at bit 3; the fixed picker then yields the round-robin order.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) rot[k] = elig[2'(k) + last_q];
    end
    assign pick_vec = rr_mode ? rot : elig;
    prio_pick u_pick (
        .vec_i (pick_vec),
        .id_o  (pick_id)
    );
    assign win  = pick_id[1:0] + (rr_mode ? last_q : 2'd0);
    assign held = req[id_q[1:0]];
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        pen_d   = pen_q;
        last_d  = last_q;
        tmo_d   = 1'b0;
        if (state_q == IDLE) begin
            pen_d = '0;
            if (!pick_id[2]) begin
                state_d = GRANT;
                grant_d = N_REQ'(1) << win;
                id_d    = {1'b0, win};
                cnt_d   = '0;
                last_d  = win;
            end
        end else if (!held) begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = NO_OWNER;
            cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
            state_d = IDLE;
            grant_d = '0;
            id_d    = NO_OWNER;
            cnt_d   = '0;
            tmo_d   = 1'b1;
            pen_d   = grant_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
    end
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= NO_OWNER;
            cnt_q   <= '0;
            pen_q   <= '0;
            last_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            pen_q   <= pen_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end
    assign grant    = grant_q;
    assign grant_id = id_q;
    assign busy     = |grant_q;
    assign timeout  = tmo_q;
endmodule
